// File: rtl/inst_fetch_arbiter_pkg.sv
// inst_fetch_arbiter_pkg
// Shared constants and types for the instruction-fetch arbiter slice.
// Contents: bus widths, ROM depth, chip-enable levels and the encoding of
// the response-owner state.
package inst_fetch_arbiter_pkg;

  localparam int InstAddrBus    = 32;
  localparam int InstBus        = 32;
  localparam int InstMemNumLog2 = 17;

  localparam logic [31:0] ZeroWord    = 32'h0000_0000;
  localparam logic        ChipEnable  = 1'b1;
  localparam logic        ChipDisable = 1'b0;

  // Who owns the response register in the cycle after a grant.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RSP_M0 = 2'd1,
    RSP_M1 = 2'd2
  } owner_e;

endpackage

// File: rtl/inst_arb_grant.sv
// inst_arb_grant
// Combinational grant decision between the fetch port (M0) and the secondary
// reader (M1), plus the arbitration state that steers it.
// Default build: M0 fixed priority, M1 forced through after STARVE_LIMIT
// consecutive denied cycles. With INST_ARB_RR_EN defined: one-bit round-robin
// pointer to the last-granted port. A flush always blocks M0.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   m0_req, m1_req     requests
//   flush              pipeline flush (blocks M0)
//   m0_gnt, m1_gnt     one-hot-or-zero grants, same cycle as request
module inst_arb_grant #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic m0_req,
  input  logic m1_req,
  input  logic flush,
  output logic m0_gnt,
  output logic m1_gnt
);

`ifdef INST_ARB_RR_EN
  // 1'b0 = M0 granted last, 1'b1 = M1 granted last.
  logic last_q, last_d;

  // Round-robin grant: on contention the port not granted last wins.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (rst) begin
      m0_gnt = 1'b0;
    end else if (m0_req && m1_req && !flush) begin
      if (last_q == 1'b0) begin
        m1_gnt = 1'b1;
      end else begin
        m0_gnt = 1'b1;
      end
    end else if (m1_req) begin
      m1_gnt = 1'b1;
    end else if (m0_req && !flush) begin
      m0_gnt = 1'b1;
    end else begin
      m0_gnt = 1'b0;
    end
  end

  // Pointer follows every grant.
  always_comb begin
    last_d = last_q;
    if (m1_gnt) begin
      last_d = 1'b1;
    end else if (m0_gnt) begin
      last_d = 1'b0;
    end else begin
      last_d = last_q;
    end
  end

  // Pointer register, reset to M0.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b0;
    end else begin
      last_q <= last_d;
    end
  end
`else
  localparam int              CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_q, starve_d;

  // Fixed M0 priority; M1 wins when M0 is idle, flushed, or M1 has starved.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (rst) begin
      m0_gnt = 1'b0;
    end else if (m1_req && (!m0_req || (starve_q == LIMIT) || flush)) begin
      m1_gnt = 1'b1;
    end else if (m0_req && !flush) begin
      m0_gnt = 1'b1;
    end else begin
      m0_gnt = 1'b0;
    end
  end

  // Count consecutive denied M1 cycles, saturating at the limit.
  always_comb begin
    starve_d = {CNT_W{1'b0}};
    if (m1_req && !m1_gnt) begin
      if (starve_q == LIMIT) begin
        starve_d = starve_q;
      end else begin
        starve_d = starve_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      starve_d = {CNT_W{1'b0}};
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= {CNT_W{1'b0}};
    end else begin
      starve_q <= starve_d;
    end
  end
`endif

endmodule

// File: rtl/inst_fetch_arbiter.sv
// inst_fetch_arbiter
// Shares the single-port instruction ROM between the IF stage (M0) and a
// secondary reader (M1). Grants are combinational; the ROM word is captured
// into a registered response one cycle after the grant. Misaligned or
// out-of-range addresses are granted but never reach the ROM and come back
// as err=1 with a zero word. A flush blocks M0 grants and kills the M0
// response currently on the outputs.
// Optional feature macro: INST_ARB_RR_EN (round-robin instead of fixed M0
// priority with starvation limit).
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   m0_* / m1_*                    req/addr in; gnt, rvalid, rdata, err out
//   flush                          pipeline flush
//   stallreq                       M0 requesting but not granted (no flush)
//   rom_ce, rom_addr, rom_inst     ROM enable/address out, read data in
module inst_fetch_arbiter
  import inst_fetch_arbiter_pkg::*;
#(
  parameter int ADDR_W         = InstAddrBus,
  parameter int DATA_W         = InstBus,
  parameter int ROM_DEPTH_LOG2 = InstMemNumLog2,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  input  logic              flush,
  output logic              stallreq,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_inst
);

  // Word-aligned and below the ROM top.
  function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
    return (a[1:0] != 2'b00) ||
           ((a >> (ROM_DEPTH_LOG2 + 2)) != {ADDR_W{1'b0}});
  endfunction

  logic              g0_s, g1_s;
  logic [ADDR_W-1:0] gnt_addr_s;
  logic              gnt_err_s;
  owner_e            owner_q, owner_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  inst_arb_grant #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_grant (
    .clk    (clk),
    .rst    (rst),
    .m0_req (m0_req),
    .m1_req (m1_req),
    .flush  (flush),
    .m0_gnt (g0_s),
    .m1_gnt (g1_s)
  );

  assign m0_gnt   = g0_s;
  assign m1_gnt   = g1_s;
  // Reset gate keeps stallreq low while grants are suppressed in reset.
  assign stallreq = m0_req & ~g0_s & ~flush & ~rst;

  // Select the granted address, drive the ROM and form the next response.
  always_comb begin
    gnt_addr_s = {ADDR_W{1'b0}};
    gnt_err_s  = 1'b0;
    rom_ce     = ChipDisable;
    rom_addr   = {ADDR_W{1'b0}};
    owner_d    = IDLE;
    rdata_d    = {DATA_W{1'b0}};
    err_d      = 1'b0;
    if (g1_s) begin
      gnt_addr_s = m1_addr;
      owner_d    = RSP_M1;
    end else if (g0_s) begin
      gnt_addr_s = m0_addr;
      owner_d    = RSP_M0;
    end else begin
      owner_d    = IDLE;
    end
    if (g0_s || g1_s) begin
      gnt_err_s = addr_bad(gnt_addr_s);
      err_d     = gnt_err_s;
      if (!gnt_err_s) begin
        rom_ce   = ChipEnable;
        rom_addr = gnt_addr_s;
        rdata_d  = rom_inst;
      end else begin
        rom_ce   = ChipDisable;
      end
    end else begin
      gnt_err_s = 1'b0;
    end
  end

  // Response register: owner, captured word and error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= IDLE;
      rdata_q <= {DATA_W{1'b0}};
      err_q   <= 1'b0;
    end else begin
      owner_q <= owner_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Route the registered response to its owner; flush kills the M0 side.
  always_comb begin
    m0_rvalid = 1'b0;
    m0_rdata  = {DATA_W{1'b0}};
    m0_err    = 1'b0;
    m1_rvalid = 1'b0;
    m1_rdata  = {DATA_W{1'b0}};
    m1_err    = 1'b0;
    case (owner_q)
      RSP_M0: begin
        if (!flush) begin
          m0_rvalid = 1'b1;
          m0_rdata  = rdata_q;
          m0_err    = err_q;
        end else begin
          m0_rvalid = 1'b0;
        end
      end
      RSP_M1: begin
        m1_rvalid = 1'b1;
        m1_rdata  = rdata_q;
        m1_err    = err_q;
      end
      default: begin
        m0_rvalid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_inst_fetch_arbiter.sv
// tb_inst_fetch_arbiter
// Directed cases followed by randomized traffic, all checked against a
// cycle-level reference model of the arbitration rules.
module tb_inst_fetch_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LOG2 = 17;
  localparam int SL   = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m1_req, flush;
  logic [AW-1:0] m0_addr, m1_addr, rom_addr;
  logic [DW-1:0] m0_rdata, m1_rdata, rom_inst;
  logic          m0_gnt, m0_rvalid, m0_err;
  logic          m1_gnt, m1_rvalid, m1_err;
  logic          stallreq, rom_ce;

  always #5 clk = ~clk;

  inst_fetch_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .ROM_DEPTH_LOG2(LOG2), .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_gnt(m1_gnt),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .flush(flush), .stallreq(stallreq),
    .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model state: consecutive M1 denials and the pending response.
  int            denied = 0;
  bit            pv = 1'b0;
  int            pport = 0;
  logic [31:0]   pdata = 32'd0;
  bit            perr = 1'b0;
  bit            last_e0 = 1'b0;

  function automatic bit bad_addr(input logic [31:0] a);
    logic [63:0] top;
    top = 64'd1 << (LOG2 + 2);
    return (a[1:0] != 2'b00) || ({32'd0, a} >= top);
  endfunction

  // Called just after a negedge once inputs are set: checks all outputs and
  // advances the model past the coming rising edge.
  task automatic tick();
    bit          e0, e1, g, ge, v0, v1;
    logic [31:0] ga;
    #1;
    e1 = !rst && m1_req && (!m0_req || denied == SL || flush);
    e0 = !rst && m0_req && !flush && !e1;
    g  = e0 || e1;
    ga = e1 ? m1_addr : m0_addr;
    ge = g && bad_addr(ga);
    v0 = pv && pport == 0 && !flush;
    v1 = pv && pport == 1;
    chk_eq("m0_gnt", m0_gnt, e0);
    chk_eq("m1_gnt", m1_gnt, e1);
    chk_eq("rom_ce", rom_ce, g && !ge);
    chk_eq("rom_addr", rom_addr, (g && !ge) ? ga : 32'd0);
    chk_eq("stallreq", stallreq, !rst && m0_req && !e0 && !flush);
    chk_eq("m0_rvalid", m0_rvalid, v0);
    chk_eq("m0_rdata", m0_rdata, v0 ? pdata : 32'd0);
    chk_eq("m0_err", m0_err, v0 && perr);
    chk_eq("m1_rvalid", m1_rvalid, v1);
    chk_eq("m1_rdata", m1_rdata, v1 ? pdata : 32'd0);
    chk_eq("m1_err", m1_err, v1 && perr);
    last_e0 = e0;
    if (rst) begin
      pv = 1'b0;
      denied = 0;
    end else begin
      pv    = g;
      pport = e1 ? 1 : 0;
      pdata = ge ? 32'd0 : rom_inst;
      perr  = ge;
      denied = (m1_req && !e1) ? ((denied + 1 > SL) ? SL : denied + 1) : 0;
    end
  endtask

  task automatic idle_inputs();
    m0_req = 1'b0; m1_req = 1'b0; flush = 1'b0;
    m0_addr = 32'd0; m1_addr = 32'd0; rom_inst = $urandom;
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7)       return $urandom & ((32'd1 << (LOG2 + 2)) - 32'd4);
    else if (r == 7) return ($urandom & 32'h0000_FFF0) | 32'd2;
    else if (r == 8) return (32'd1 << (LOG2 + 2)) | ($urandom & 32'h0000_FFFC);
    else             return (32'd1 << (LOG2 + 2)) - 32'd4;
  endfunction

  initial begin
    rst = 1'b1;
    idle_inputs();
    // Reset: every output low.
    @(negedge clk); tick();
    @(negedge clk); tick();
    chk_eq("rst_rom_ce", rom_ce, 1'b0);
    chk_eq("rst_m0_rvalid", m0_rvalid, 1'b0);

    // Basic M0 fetch.
    @(negedge clk); rst = 1'b0; m0_req = 1'b1; m0_addr = 32'h0000_0004;
    rom_inst = 32'h3401_4044; tick();
    chk_eq("fetch_gnt", m0_gnt, 1'b1);
    chk_eq("fetch_rom_addr", rom_addr, 32'h4);
    @(negedge clk); idle_inputs(); tick();
    chk_eq("fetch_rvalid", m0_rvalid, 1'b1);
    chk_eq("fetch_rdata", m0_rdata, 32'h3401_4044);

    // Both ports held: M1 forced through on the fifth cycle.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      m0_req = 1'b1; m0_addr = 32'h8; m1_req = 1'b1; m1_addr = 32'h10;
      rom_inst = $urandom; tick();
      chk_eq("starve_m1_gnt", m1_gnt, i == 4);
      chk_eq("starve_m0_gnt", m0_gnt, i != 4);
      chk_eq("starve_stall", stallreq, i == 4);
    end
    @(negedge clk); idle_inputs(); tick();

    // Misaligned M1 access.
    @(negedge clk); m1_req = 1'b1; m1_addr = 32'h6; tick();
    chk_eq("misalign_gnt", m1_gnt, 1'b1);
    chk_eq("misalign_ce", rom_ce, 1'b0);
    @(negedge clk); idle_inputs(); tick();
    chk_eq("misalign_err", m1_err, 1'b1);
    chk_eq("misalign_rvalid", m1_rvalid, 1'b1);

    // Out-of-range M0 access.
    @(negedge clk); m0_req = 1'b1; m0_addr = 32'd1 << (LOG2 + 2); tick();
    chk_eq("oor_ce", rom_ce, 1'b0);
    @(negedge clk); idle_inputs(); tick();
    chk_eq("oor_err", m0_err, 1'b1);
    chk_eq("oor_rdata", m0_rdata, 32'd0);

    // Flush one cycle after an M0 grant.
    @(negedge clk); m0_req = 1'b1; m0_addr = 32'h20; rom_inst = $urandom; tick();
    @(negedge clk); flush = 1'b1; m0_addr = 32'h24; m1_req = 1'b1; m1_addr = 32'h30;
    rom_inst = $urandom; tick();
    chk_eq("flush_rvalid", m0_rvalid, 1'b0);
    chk_eq("flush_gnt", m0_gnt, 1'b0);
    chk_eq("flush_stall", stallreq, 1'b0);
    chk_eq("flush_m1_gnt", m1_gnt, 1'b1);
    @(negedge clk); flush = 1'b0; m1_req = 1'b0; tick();
    @(negedge clk); idle_inputs(); tick();

    // Reset right after a grant drops the response.
    @(negedge clk); m0_req = 1'b1; m0_addr = 32'h40; tick();
    @(negedge clk); idle_inputs(); rst = 1'b1; tick();
    @(negedge clk); rst = 1'b0; tick();
    chk_eq("rst_drop_rvalid", m0_rvalid, 1'b0);
    chk_eq("rst_drop_rdata", m0_rdata, 32'd0);
    @(negedge clk); m0_req = 1'b1; m0_addr = 32'h44; tick();
    chk_eq("post_rst_gnt", m0_gnt, 1'b1);
    @(negedge clk); idle_inputs(); tick();

    // Random traffic; requests hold until the model grants them.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 199) == 0);
      if (!(m0_req && !last_e0)) begin
        m0_req  = ($urandom_range(0, 99) < 60);
        m0_addr = rand_addr();
      end
      if (!(m1_req && !m1_gnt_model_pending())) begin
        m1_req  = ($urandom_range(0, 99) < 35);
        m1_addr = rand_addr();
      end
      flush    = ($urandom_range(0, 99) < 8);
      rom_inst = $urandom;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  // True when last cycle's M1 request was granted by the model.
  function automatic bit m1_gnt_model_pending();
    return pv && pport == 1;
  endfunction

endmodule
